// File: rtl/fp_pkg.sv
// Shared types, default widths and significand field positions for the normalizer.
// Significand layout, MSB first: [carry | hidden | mantissa | rounding].
package fp_pkg;

    localparam int unsigned DEFAULT_EXPONENT_WIDTH = 8;
    localparam int unsigned DEFAULT_MANTISSA_WIDTH = 23;
    localparam int unsigned DEFAULT_ROUNDING_BITS  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } norm_state_t;

    function automatic int unsigned sig_width(input int unsigned mantissa_width,
                                              input int unsigned rounding_bits);
        return mantissa_width + rounding_bits + 2;
    endfunction

    function automatic int unsigned carry_index(input int unsigned mantissa_width,
                                                input int unsigned rounding_bits);
        return mantissa_width + rounding_bits + 1;
    endfunction

    function automatic int unsigned hidden_index(input int unsigned mantissa_width,
                                                 input int unsigned rounding_bits);
        return mantissa_width + rounding_bits;
    endfunction

endpackage

// File: rtl/normalize_shift_step.sv
// One normalization step: right shift with sticky LSB and exponent +1, or
// left shift and exponent -1, with the range checks done one bit wider.
module normalize_shift_step #(
    parameter int unsigned EXPONENT_WIDTH = 8,
    parameter int unsigned SIG_WIDTH      = 28
) (
    input  logic                      right,
    input  logic [EXPONENT_WIDTH-1:0] exponent,
    input  logic [SIG_WIDTH-1:0]      significand,
    output logic [EXPONENT_WIDTH-1:0] exponent_c,
    output logic [SIG_WIDTH-1:0]      significand_c,
    output logic                      overflow_c,
    output logic                      underflow_c
);

    localparam int unsigned EXT_WIDTH = EXPONENT_WIDTH + 1;

    logic [EXT_WIDTH-1:0] exp_wide;

    always_comb begin
        if (right) begin
            // Bit shifted out is folded into the new LSB so sticky survives.
            significand_c = {1'b0, significand[SIG_WIDTH-1:2], significand[1] | significand[0]};
            exp_wide      = EXT_WIDTH'(exponent) + EXT_WIDTH'(1);
        end else begin
            significand_c = {significand[SIG_WIDTH-2:0], 1'b0};
            exp_wide      = EXT_WIDTH'(exponent) - EXT_WIDTH'(1);
        end
        exponent_c  = exp_wide[EXPONENT_WIDTH-1:0];
        overflow_c  = right & (exp_wide[EXPONENT_WIDTH] | (&exp_wide[EXPONENT_WIDTH-1:0]));
        underflow_c = !right & (exp_wide[EXPONENT_WIDTH] | (exp_wide[EXPONENT_WIDTH-1:0] == '0));
    end

endmodule

// File: rtl/result_normalizer.sv
// Multi-cycle significand normalizer feeding result_rounder over valid/ready.
// RESULT_NORMALIZER_SUBNORMAL_EN keeps subnormal mantissas; otherwise they flush to zero.
module result_normalizer
    import fp_pkg::*;
#(
    parameter int unsigned EXPONENT_WIDTH = DEFAULT_EXPONENT_WIDTH,
    parameter int unsigned MANTISSA_WIDTH = DEFAULT_MANTISSA_WIDTH,
    parameter int unsigned ROUNDING_BITS  = DEFAULT_ROUNDING_BITS
) (
    input  logic                                                clk,
    input  logic                                                rst_n,
    input  logic                                                in_valid,
    output logic                                                in_ready,
    input  logic [EXPONENT_WIDTH-1:0]                           in_exponent,
    input  logic [sig_width(MANTISSA_WIDTH, ROUNDING_BITS)-1:0] in_significand,
    output logic                                                out_valid,
    input  logic                                                out_ready,
    output logic [EXPONENT_WIDTH-1:0]                           out_exponent,
    output logic [MANTISSA_WIDTH-1:0]                           out_mantissa,
    output logic [ROUNDING_BITS-1:0]                            out_rounding_bits,
    output logic                                                out_overflow
);

    localparam int unsigned SIG_WIDTH  = sig_width(MANTISSA_WIDTH, ROUNDING_BITS);
    localparam int unsigned CARRY_IDX  = carry_index(MANTISSA_WIDTH, ROUNDING_BITS);
    localparam int unsigned HIDDEN_IDX = hidden_index(MANTISSA_WIDTH, ROUNDING_BITS);

    norm_state_t               state, state_next;
    logic [EXPONENT_WIDTH-1:0] exp_q, exp_next;
    logic [SIG_WIDTH-1:0]      sig_q, sig_next;
    logic [EXPONENT_WIDTH-1:0] out_exponent_next;
    logic [MANTISSA_WIDTH-1:0] out_mantissa_next;
    logic [ROUNDING_BITS-1:0]  out_rounding_bits_next;
    logic                      out_overflow_next;
    logic                      in_ready_next, out_valid_next;

    logic                      done_now, res_ovf;
    logic [EXPONENT_WIDTH-1:0] res_exp;
    logic [MANTISSA_WIDTH-1:0] res_mant;
    logic [ROUNDING_BITS-1:0]  res_rb;

    logic [EXPONENT_WIDTH-1:0] step_exponent;
    logic [SIG_WIDTH-1:0]      step_significand;
    logic                      step_overflow, step_underflow;

    // Direction follows the carry bit: carry set means the single right shift.
    normalize_shift_step #(
        .EXPONENT_WIDTH(EXPONENT_WIDTH),
        .SIG_WIDTH     (SIG_WIDTH)
    ) u_step (
        .right        (sig_q[CARRY_IDX]),
        .exponent     (exp_q),
        .significand  (sig_q),
        .exponent_c   (step_exponent),
        .significand_c(step_significand),
        .overflow_c   (step_overflow),
        .underflow_c  (step_underflow)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state             <= IDLE;
            exp_q             <= '0;
            sig_q             <= '0;
            out_exponent      <= '0;
            out_mantissa      <= '0;
            out_rounding_bits <= '0;
            out_overflow      <= 1'b0;
            in_ready          <= 1'b1;
            out_valid         <= 1'b0;
        end else begin
            state             <= state_next;
            exp_q             <= exp_next;
            sig_q             <= sig_next;
            out_exponent      <= out_exponent_next;
            out_mantissa      <= out_mantissa_next;
            out_rounding_bits <= out_rounding_bits_next;
            out_overflow      <= out_overflow_next;
            in_ready          <= in_ready_next;
            out_valid         <= out_valid_next;
        end
    end

    always_comb begin
        state_next             = state;
        exp_next               = exp_q;
        sig_next               = sig_q;
        out_exponent_next      = out_exponent;
        out_mantissa_next      = out_mantissa;
        out_rounding_bits_next = out_rounding_bits;
        out_overflow_next      = out_overflow;
        done_now               = 1'b0;
        res_ovf                = 1'b0;
        res_exp                = '0;
        res_mant               = '0;
        res_rb                 = '0;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    exp_next   = in_exponent;
                    sig_next   = in_significand;
                    state_next = NORM;
                end
            end
            NORM: begin
                // Result defaults to all-zero, which is the zero-significand answer.
                done_now = 1'b1;
                if (sig_q == '0) begin
                    res_ovf = 1'b0;
                end else if (&exp_q) begin
                    res_ovf = 1'b1;
                end else if (sig_q[CARRY_IDX]) begin
                    if (step_overflow) begin
                        res_ovf = 1'b1;
                    end else begin
                        res_exp  = step_exponent;
                        res_mant = step_significand[HIDDEN_IDX-1 -: MANTISSA_WIDTH];
                        res_rb   = step_significand[ROUNDING_BITS-1:0];
                    end
                end else if (sig_q[HIDDEN_IDX]) begin
                    res_exp  = exp_q;
                    res_mant = sig_q[HIDDEN_IDX-1 -: MANTISSA_WIDTH];
                    res_rb   = sig_q[ROUNDING_BITS-1:0];
                end else if (step_underflow) begin
`ifdef RESULT_NORMALIZER_SUBNORMAL_EN
                    res_mant = sig_q[HIDDEN_IDX-1 -: MANTISSA_WIDTH];
                    res_rb   = sig_q[ROUNDING_BITS-1:0];
`else
                    res_ovf  = 1'b0;
`endif
                end else begin
                    done_now = 1'b0;
                    exp_next = step_exponent;
                    sig_next = step_significand;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (done_now) begin
            state_next             = DONE;
            out_exponent_next      = res_ovf ? '1 : res_exp;
            out_mantissa_next      = res_mant;
            out_rounding_bits_next = res_rb;
            out_overflow_next      = res_ovf;
        end

        in_ready_next  = (state_next == IDLE);
        out_valid_next = (state_next == DONE);
    end

endmodule

// File: tb/tb_result_normalizer.sv
// Directed self-checking bench for result_normalizer at default widths (8/23/3).
// Honours RESULT_NORMALIZER_SUBNORMAL_EN for the subnormal expectations.
module tb_result_normalizer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_exponent;
    logic [27:0] in_significand;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_exponent;
    logic [22:0] out_mantissa;
    logic [2:0]  out_rounding_bits;
    logic        out_overflow;

    int tests_run = 0;
    int tests_failed = 0;

    result_normalizer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_exponent      (in_exponent),
        .in_significand   (in_significand),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_exponent     (out_exponent),
        .out_mantissa     (out_mantissa),
        .out_rounding_bits(out_rounding_bits),
        .out_overflow     (out_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends one beat, checks latency in edges after acceptance, then the result.
    task automatic run(input string tag, input logic [7:0] e, input logic [27:0] s,
                       input int shifts, input logic [7:0] xe, input logic [22:0] xm,
                       input logic [2:0] xr, input logic xo);
        int n;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid       = 1'b1;
        in_exponent    = e;
        in_significand = s;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(1 + shifts));
        check({tag, "_exp"}, 32'(out_exponent), 32'(xe));
        check({tag, "_mant"}, 32'(out_mantissa), 32'(xm));
        check({tag, "_rb"}, 32'(out_rounding_bits), 32'(xr));
        check({tag, "_ovf"}, 32'(out_overflow), 32'(xo));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_release"}, 32'({in_ready, out_valid}), 32'b10);
    endtask

    initial begin
        int n;
        logic seen_valid;
        rst_n          = 1'b0;
        in_valid       = 1'b0;
        in_exponent    = '0;
        in_significand = '0;
        out_ready      = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_data", 32'({out_exponent, out_mantissa, out_rounding_bits}), 32'd0);
        check("reset_ovf", 32'(out_overflow), 32'd0);

        run("already_norm", 8'd127, 28'h4000000, 0, 8'd127, 23'h0, 3'b000, 1'b0);
        run("carry_sticky", 8'd127, 28'h8000001, 0, 8'd128, 23'h0, 3'b001, 1'b0);
        run("carry_mant",   8'd200, 28'hC000003, 0, 8'd201, 23'h400000, 3'b001, 1'b0);
        run("left_two",     8'd10,  28'h1000000, 2, 8'd8, 23'h0, 3'b000, 1'b0);
        run("left_rb",      8'd50,  28'h2000006, 1, 8'd49, 23'h000001, 3'b100, 1'b0);
`ifdef RESULT_NORMALIZER_SUBNORMAL_EN
        run("subnorm_walk", 8'd3,   28'h0000008, 2, 8'd0, 23'h000004, 3'b000, 1'b0);
        run("subnorm_e1",   8'd1,   28'h0800000, 0, 8'd0, 23'h100000, 3'b000, 1'b0);
`else
        run("subnorm_walk", 8'd3,   28'h0000008, 2, 8'd0, 23'h0, 3'b000, 1'b0);
        run("subnorm_e1",   8'd1,   28'h0800000, 0, 8'd0, 23'h0, 3'b000, 1'b0);
`endif
        run("exp0_hidden",  8'd0,   28'h4000005, 0, 8'd0, 23'h0, 3'b101, 1'b0);
        run("carry_ovf",    8'd254, 28'h8000000, 0, 8'd255, 23'h0, 3'b000, 1'b1);
        run("exp_allones",  8'd255, 28'h4000007, 0, 8'd255, 23'h0, 3'b000, 1'b1);
        run("zero_sig",     8'd100, 28'h0000000, 0, 8'd0, 23'h0, 3'b000, 1'b0);

        // Backpressure: result must hold while out_ready is low and in_valid is ignored.
        in_valid       = 1'b1;
        in_exponent    = 8'd127;
        in_significand = 28'h8000001;
        tick();
        in_exponent    = 8'd5;
        in_significand = 28'h0000001;
        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            n++;
        end
        check("bp_latency", 32'(n), 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_data", 32'({out_exponent, out_mantissa[0], out_rounding_bits}),
                  32'({8'd128, 1'b0, 3'b001}));
            check("bp_hold_flags", 32'({out_valid, in_ready, out_overflow}), 32'b100);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release", 32'({in_ready, out_valid}), 32'b10);

        // Reset pulse while walking leading zeros discards the beat.
        in_valid       = 1'b1;
        in_exponent    = 8'd100;
        in_significand = 28'h0000100;
        tick();
        in_valid = 1'b0;
        tick();
        check("rst_mid_busy", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        seen_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            seen_valid |= out_valid;
            tick();
        end
        check("rst_mid_no_valid", 32'(seen_valid), 32'd0);
        check("rst_mid_in_ready", 32'(in_ready), 32'd1);
        check("rst_mid_data", 32'({out_exponent, out_rounding_bits}), 32'd0);

        run("after_reset", 8'd10, 28'h1000000, 2, 8'd8, 23'h0, 3'b000, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
